relu_requant_stage: RTL and testbench

- Upstream neighbour of the NPU argmax comparator.
- Takes groups of four signed 32-bit MAC accumulators, adds a per-lane bias, applies a rounding arithmetic right shift, optional ReLU and 16-bit saturation.
- Presents four 16-bit lanes plus a one-cycle trig pulse, paced so the comparator's one-cycle-delayed sampling always sees stable data.
- Sequences one inference: clears the comparator, counts groups, signals completion.

---
 rtl/npu_pkg.sv | 40 ++++
 rtl/requant_lane.sv | 58 +++++
 rtl/relu_requant_stage.sv | 147 ++++++++++++++
 tb/tb_relu_requant_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU datapath widths, state encoding and the requant clamp helper.
// Used by the requant stage and its per-lane datapath.
package npu_pkg;

    localparam int ACC_W  = 32;
    localparam int BIAS_W = 16;
    localparam int DATA_W = 16;
    localparam int LANES  = 4;

    // Width of the rounded sum: bias add needs one guard bit, the rounding add one more.
    localparam int RND_W = ACC_W + 2;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic signed [DATA_W-1:0] clamp_data(
        input logic signed [RND_W-1:0] v,
        input logic                    relu
    );
        logic signed [DATA_W-1:0] r;
        if (relu && (v < 0)) begin
            r = '0;
        end else if (v > SAT_MAX) begin
            r = SAT_MAX;
        end else if (v < SAT_MIN) begin
            r = SAT_MIN;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One requant lane: stage 1 registers acc + bias, stage 2 registers the
// round-shifted, optionally rectified and saturated 16-bit result.
module requant_lane
    import npu_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     relu_en,
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic                     adv,
    output logic signed [DATA_W-1:0] q
);

    localparam logic signed [RND_W-1:0] ROUND = {{(RND_W-1){1'b0}}, 1'b1} << (SHIFT - 1);

    logic signed [ACC_W:0]    sum_q, sum_d;
    logic                     relu_q, relu_d;
    logic signed [DATA_W-1:0] q_q, q_d;
    logic signed [RND_W-1:0]  rounded;
    logic signed [RND_W-1:0]  shifted;

    always_comb begin
        sum_d  = sum_q;
        relu_d = relu_q;
        if (load) begin
            sum_d  = {acc[ACC_W-1], acc} + {{(ACC_W+1-BIAS_W){bias[BIAS_W-1]}}, bias};
            relu_d = relu_en;
        end
    end

    always_comb begin
        rounded = {sum_q[ACC_W], sum_q} + ROUND;
        shifted = rounded >>> SHIFT;
        q_d     = q_q;
        if (adv) begin
            q_d = clamp_data(shifted, relu_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q  <= '0;
            relu_q <= 1'b0;
            q_q    <= '0;
        end else begin
            sum_q  <= sum_d;
            relu_q <= relu_d;
            q_q    <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/relu_requant_stage.sv
// Requant stage feeding the argmax comparator: four requant lanes, the
// inference sequencer, output pacing, group counting and overflow flag.
module relu_requant_stage
    import npu_pkg::*;
#(
    parameter int SHIFT      = 8,
    parameter int MAX_GROUPS = 63
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      relu_en,
    input  logic [LANES*ACC_W-1:0]    acc_in,
    input  logic [LANES*BIAS_W-1:0]   bias_in,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic signed [DATA_W-1:0]  out1,
    output logic signed [DATA_W-1:0]  out2,
    output logic signed [DATA_W-1:0]  out3,
    output logic signed [DATA_W-1:0]  out4,
    output logic                      trig,
    output logic                      cmp_clear,
    output logic [5:0]                group_count,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output state_e                    dbg_state
);

    state_e     state_q, state_d;
    logic       s1_v_q, s1_v_d;
    logic       s1_last_q, s1_last_d;
    logic       trig_q, trig_d;
    logic       trig_last_q, trig_last_d;
    logic       tail_q, tail_d;
    logic       cmp_clear_q, cmp_clear_d;
    logic [5:0] count_q, count_d;
    logic       err_q, err_d;
    logic       accept;

    logic signed [DATA_W-1:0] lane_out [LANES];

    // Handshake: a group transfers on any edge where in_valid && in_ready.
    // in_ready is low outside RUN, during the cmp_clear cycle and in the
    // cycle after an accept, so accepts are >= 2 cycles apart and trigs never touch.
    assign in_ready = (state_q == ST_RUN) && !s1_v_q && !cmp_clear_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cmp_clear_d = 1'b0;
        count_d     = count_q;
        err_d       = err_q;
        s1_v_d      = accept;
        s1_last_d   = accept && in_last;
        trig_d      = s1_v_q;
        trig_last_d = s1_v_q && s1_last_q;
        tail_d      = trig_q && trig_last_q;

        if (s1_v_q) begin
            if (count_q == 6'(MAX_GROUPS)) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + 6'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    cmp_clear_d = 1'b1;
                    count_d     = '0;
                    err_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            // tail_q marks the comparator's delayed-sample cycle after the last trig.
            ST_DRAIN: begin
                if (tail_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            trig_q      <= 1'b0;
            trig_last_q <= 1'b0;
            tail_q      <= 1'b0;
            cmp_clear_q <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
            trig_q      <= trig_d;
            trig_last_q <= trig_last_d;
            tail_q      <= tail_d;
            cmp_clear_q <= cmp_clear_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        requant_lane #(.SHIFT(SHIFT)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (accept),
            .relu_en (relu_en),
            .acc     (acc_in[i*ACC_W +: ACC_W]),
            .bias    (bias_in[i*BIAS_W +: BIAS_W]),
            .adv     (s1_v_q),
            .q       (lane_out[i])
        );
    end

    assign out1        = lane_out[0];
    assign out2        = lane_out[1];
    assign out3        = lane_out[2];
    assign out4        = lane_out[3];
    assign trig        = trig_q;
    assign cmp_clear   = cmp_clear_q;
    assign group_count = count_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_relu_requant_stage.sv
// Directed bench for relu_requant_stage: driver tasks push expected lane
// words into exp_q, a negedge monitor pops and compares on every trig.
module tb_relu_requant_stage;
    import npu_pkg::*;

    logic         clk;
    logic         reset;
    logic         start;
    logic         relu_en;
    logic [127:0] acc_in;
    logic [63:0]  bias_in;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [15:0]  out1, out2, out3, out4;
    logic         trig;
    logic         cmp_clear;
    logic [5:0]   group_count;
    logic         busy;
    logic         done;
    logic         err;
    state_e       dbg_state;

    relu_requant_stage #(.SHIFT(8), .MAX_GROUPS(63)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .relu_en     (relu_en),
        .acc_in      (acc_in),
        .bias_in     (bias_in),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .out4        (out4),
        .trig        (trig),
        .cmp_clear   (cmp_clear),
        .group_count (group_count),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          trig_count = 0;
    int          done_count = 0;
    int          since_trig = 100;
    int          since_clr  = 100;
    logic        prev_trig  = 1'b0;
    logic [63:0] hold_val   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return {out4, out3, out2, out1};
    endfunction

    function automatic logic [11:0] ctrl();
        return {trig, cmp_clear, group_count, busy, done, err, in_ready};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            prev_trig  = 1'b0;
            since_trig = 100;
            since_clr  = 100;
        end else begin
            since_trig = trig ? 0 : ((since_trig < 100) ? since_trig + 1 : 100);
            since_clr  = cmp_clear ? 0 : ((since_clr < 100) ? since_clr + 1 : 100);
            if (prev_trig) check("hold_after_trig", outs(), hold_val);
            if (trig) begin
                trig_count++;
                check("trig_adjacent", {63'd0, prev_trig}, 64'd0);
                check("clear_with_trig", {63'd0, cmp_clear}, 64'd0);
                check("clear_to_trig_ge3", {63'd0, since_clr >= 3}, 64'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_trig: got %h expected none at %0t", outs(), $time);
                end else begin
                    check("lane_out", outs(), exp_q.pop_front());
                end
                hold_val = outs();
            end
            if (done) begin
                done_count++;
                check("done_gap", 64'(since_trig), 64'd2);
            end
            prev_trig = trig;
        end
    end

    // Driver tasks
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_cmp_clear", {63'd0, cmp_clear}, 64'd1);
        check("start_count", {58'd0, group_count}, 64'd0);
        check("start_err", {63'd0, err}, 64'd0);
        check("start_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic send(input logic [127:0] a, input logic [63:0] b, input logic r,
                        input logic last, input logic [63:0] e, output int stalls);
        @(negedge clk);
        acc_in   = a;
        bias_in  = b;
        relu_en  = r;
        in_last  = last;
        in_valid = 1'b1;
        stalls   = 0;
        while (!in_ready && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 at %0t", $time);
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic drop();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got done=0 expected 1 at %0t", $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int t0;
        int d0;
        reset    = 1'b0;
        start    = 1'b0;
        relu_en  = 1'b0;
        acc_in   = '0;
        bias_in  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #12;
        check("reset_outs", outs(), 64'd0);
        check("reset_ctrl", {52'd0, ctrl()}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single group
        do_start();
        send({32'd0, 32'd0, 32'd0, 32'h0000_1234}, 64'd0, 1'b0, 1'b1,
             {16'd0, 16'd0, 16'd0, 16'h0012}, st);
        drop();
        wait_done();
        check("single_count", {58'd0, group_count}, 64'd1);
        check("single_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        check("single_idle", {63'd0, busy}, 64'd0);

        // ReLU off then on
        do_start();
        send({32'd0, 32'd0, 32'h0000_0100, 32'hFFFF_FC18}, {16'd0, 16'd0, 16'd1, 16'd0},
             1'b0, 1'b0, {16'd0, 16'd0, 16'h0001, 16'hFFFC}, st);
        send({32'd0, 32'd0, 32'h0000_0100, 32'hFFFF_FC18}, {16'd0, 16'd0, 16'd1, 16'd0},
             1'b1, 1'b1, {16'd0, 16'd0, 16'h0001, 16'h0000}, st);
        drop();
        wait_done();
        check("relu_count", {58'd0, group_count}, 64'd2);

        // Saturation and rounding boundaries
        do_start();
        send({32'hFFFF_FF7F, 32'hFFFF_FF80, 32'h8000_0000, 32'h7FFF_FFFF},
             {16'd0, 16'd0, 16'h8000, 16'h7FFF}, 1'b0, 1'b1,
             {16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF}, st);
        drop();
        wait_done();

        // Pacing with in_valid held high
        do_start();
        for (int g = 1; g <= 5; g++) begin
            send({32'd0, 32'(g << 16), 32'(-(g * 256)), 32'(g * 256)}, 64'd0, 1'b0, (g == 5),
                 {16'd0, 16'(g * 256), 16'(-g), 16'(g)}, st);
            if (g > 1) check("pace_stall", 64'(st), 64'd1);
        end
        drop();
        wait_done();
        check("pace_count", {58'd0, group_count}, 64'd5);

        // Overflow past MAX_GROUPS
        do_start();
        for (int i = 0; i <= 64; i++) begin
            send({96'd0, 32'(i * 256)}, 64'd0, 1'b0, (i == 64), {48'd0, 16'(i)}, st);
        end
        drop();
        wait_done();
        check("ovf_count", {58'd0, group_count}, 64'd63);
        check("ovf_err", {63'd0, err}, 64'd1);

        // Async reset with group 3 in flight
        do_start();
        check("err_cleared", {63'd0, err}, 64'd0);
        send({96'd0, 32'h0000_0100}, 64'd0, 1'b0, 1'b0, {48'd0, 16'd1}, st);
        send({96'd0, 32'h0000_0200}, 64'd0, 1'b0, 1'b0, {48'd0, 16'd2}, st);
        send({96'd0, 32'h0000_0300}, 64'd0, 1'b0, 1'b0, {48'd0, 16'd3}, st);
        drop();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_reset_outs", outs(), 64'd0);
        check("mid_reset_ctrl", {52'd0, ctrl()}, 64'd0);
        exp_q.delete();
        t0 = trig_count;
        d0 = done_count;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_no_trig", 64'(trig_count), 64'(t0));
        check("post_reset_no_done", 64'(done_count), 64'(d0));
        check("post_reset_idle", {63'd0, busy}, 64'd0);

        do_start();
        send({96'd0, 32'h0000_0480}, 64'd0, 1'b0, 1'b1, {48'd0, 16'd5}, st);
        drop();
        wait_done();
        check("restart_count", {58'd0, group_count}, 64'd1);
        check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
